// File: rtl/d_flop.sv
// D flip-flop with load enable and synchronous active-low reset.
// Reset takes priority over the enable. The output comes straight from the register.
module d_flop #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_ip,
  input  logic             en_ip,
  output logic [WIDTH-1:0] q_op
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // The hold path recirculates q_q when the enable is low.
  always_comb begin
    q_d = q_q;
    if (en_ip) q_d = d_ip;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q_op = q_q;

endmodule

// File: tb/tb_d_flop.sv
// Testbench for d_flop. It applies a table of directed vectors, a set of
// between-edge sequences, and a random phase. Expected values are queued.
module tb_d_flop;

  typedef struct {
    logic rst_n;
    logic en;
    logic d;
    logic exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic d_ip;
  logic en_ip;
  logic q_op;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic model_q;
  vec_t tbl[18];

  always #5 clk = ~clk;

  d_flop #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_ip  (d_ip),
    .en_ip (en_ip),
    .q_op  (q_op)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q_op=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, queue the expected output, then wait one edge and compare.
  task automatic step(input logic r, input logic e, input logic d,
                      input logic exp, input string name);
    logic want;
    rst_n = r;
    en_ip = e;
    d_ip  = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, q_op, want);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 4; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    en_ip = 1'b0;
    d_ip  = 1'b0;

    for (int i = 0; i < 18; i++)
      step(tbl[i].rst_n, tbl[i].en, tbl[i].d, tbl[i].exp, $sformatf("table[%0d]", i));

    // Load a 1. Then pulse rst_n low between edges only.
    step(1'b1, 1'b1, 1'b1, 1'b1, "load_before_pulse");
    #2 rst_n = 1'b0;
    #1 check("rst_pulse_no_async_clear", q_op, 1'b1);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, "after_rst_pulse_hold");

    // Enable and data glitch between edges but return to idle before the edge.
    en_ip = 1'b1;
    d_ip  = 1'b0;
    #2 check("glitch_no_comb_path", q_op, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, "after_glitch_hold");

    // Random phase, checked against a reference model.
    model_q = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic r, e, d;
      r = ($urandom_range(0, 7) != 0);
      e = $urandom_range(0, 1) != 0;
      d = $urandom_range(0, 1) != 0;
      if (!r)     model_q = 1'b0;
      else if (e) model_q = d;
      step(r, e, d, model_q, $sformatf("random[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
